// File: rtl/ne16_accumulator_scm_bist_ctrl_pkg.sv
// Shared types and constants for the NE16 accumulator SCM March C- BIST controller.
// Package name: ne16_bist_pkg. It holds the FSM state enum, the march element
// descriptor, the March C- element table and the background pattern function.
package ne16_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bist_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } march_dir_e;

    // Encoded so the op value can drive the active-low write enable directly.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } march_op_e;

    // data_inv is the polarity of op0 relative to the background.
    // op1, when present, always uses the opposite polarity.
    typedef struct packed {
        march_dir_e dir;
        march_op_e  op0;
        march_op_e  op1;
        logic       has_op1;
        logic       data_inv;
    } march_elem_t;

    localparam int MARCH_LEN = 6;

    // E0 up(wB), E1 up(rB,w~B), E2 up(r~B,wB), E3 down(rB,w~B), E4 down(r~B,wB), E5 up(rB)
    localparam march_elem_t MARCH_C_MINUS [MARCH_LEN] = '{
        '{DIR_UP,   OP_WRITE, OP_WRITE, 1'b0, 1'b0},
        '{DIR_UP,   OP_READ,  OP_WRITE, 1'b1, 1'b0},
        '{DIR_UP,   OP_READ,  OP_WRITE, 1'b1, 1'b1},
        '{DIR_DOWN, OP_READ,  OP_WRITE, 1'b1, 1'b0},
        '{DIR_DOWN, OP_READ,  OP_WRITE, 1'b1, 1'b1},
        '{DIR_UP,   OP_READ,  OP_READ,  1'b0, 1'b0}
    };

    // Widest word the background generator covers; callers slice their width.
    localparam int BG_MAX_W = 256;

    // Background word: solid zeros, or 0x55.. on even / 0xAA.. on odd addresses.
    function automatic logic [BG_MAX_W-1:0] bg_word(input logic checker_pass,
                                                    input logic odd_addr);
        logic [BG_MAX_W-1:0] w;
        if (!checker_pass)
            w = '0;
        else if (odd_addr)
            w = {(BG_MAX_W/2){2'b10}};
        else
            w = {(BG_MAX_W/2){2'b01}};
        return w;
    endfunction

endpackage

// File: rtl/ne16_accumulator_scm_bist_ctrl_if.sv
// Bus bundle between the BIST controller, the DFT controller and the SCM BIST port.
// The master modport is the controller side; slave is the environment side.
interface ne16_accumulator_scm_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  fail_o;
    logic [ADDR_WIDTH-1:0] fail_addr_o;
    logic [DATA_WIDTH-1:0] fail_data_o;
    logic [CNT_WIDTH-1:0]  err_count_o;
    logic                  bist_o;
    logic                  csn_t_o;
    logic                  wen_t_o;
    logic [ADDR_WIDTH-1:0] a_t_o;
    logic [DATA_WIDTH-1:0] d_t_o;
    logic [DATA_WIDTH-1:0] q_t_i;

    modport master (
        input  start_i, q_t_i,
        output busy_o, done_o, fail_o, fail_addr_o, fail_data_o, err_count_o,
               bist_o, csn_t_o, wen_t_o, a_t_o, d_t_o
    );

    modport slave (
        output start_i, q_t_i,
        input  busy_o, done_o, fail_o, fail_addr_o, fail_data_o, err_count_o,
               bist_o, csn_t_o, wen_t_o, a_t_o, d_t_o
    );
endinterface

// File: rtl/ne16_accumulator_scm_bist_ctrl_addr_gen.sv
// Up/down march address counter. Load places the counter at the start address
// of the requested direction; enable steps it in the current direction. The
// terminal-count flag compares explicitly against NUM_WORDS-1 / 0, so word
// counts that are not a power of two never rely on natural wrap.
module ne16_bist_addr_gen #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  en,
    input  logic                  dir_down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] addr_nxt,
    output logic                  tc
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

    // Next address and terminal count for the current direction.
    always_comb begin
        addr_nxt = addr;
        if (load)
            addr_nxt = load_down ? LAST : '0;
        else if (en)
            addr_nxt = dir_down ? addr - 1'b1 : addr + 1'b1;
        tc = dir_down ? (addr == '0) : (addr == LAST);
    end

    // Address register; it is also the registered SCM op address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            addr <= '0;
        else
            addr <= addr_nxt;
    end
endmodule

// File: rtl/ne16_accumulator_scm_bist_ctrl.sv
// March C- BIST initiator for one NE16 accumulator SCM bank. It drives the SCM
// BIST port one op per cycle, compares read data after READ_LATENCY cycles and
// reports a sticky fail flag, the first failing address/syndrome and a
// saturating error count. Optional macro NE16_BIST_CHECKERBOARD_EN adds a
// second full march with a 0x55/0xAA checkerboard background.
module ne16_accumulator_scm_bist_ctrl
    import ne16_bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 2**ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    ne16_accumulator_scm_bist_ctrl_if.master   bus
);
`ifdef NE16_BIST_CHECKERBOARD_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic       PASS_LAST  = 1'(NB - 1);
    localparam logic [2:0] ELEM_LAST  = 3'(MARCH_LEN - 1);
    localparam int         DRAIN_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(READ_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] ERR_MAX  = '1;

    bist_state_e          state_q;
    logic [2:0]           elem_q;
    logic                 phase_q;
    logic                 pass_q;
    logic [DRAIN_W-1:0]   drain_q;

    march_elem_t          cur_el;
    march_elem_t          nxt_el;
    logic [2:0]           nxt_elem;
    logic                 nxt_phase;
    logic                 nxt_pass;
    logic                 run_last;
    logic                 start_acc;
    logic                 issue;
    march_op_e            nxt_op;
    logic [BG_MAX_W-1:0]  bg_full;
    logic [DATA_WIDTH-1:0] nxt_data;

    logic                  ag_load;
    logic                  ag_load_down;
    logic                  ag_en;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic [ADDR_WIDTH-1:0] ag_addr_nxt;
    logic                  ag_tc;

    logic                  vld_p  [0:READ_LATENCY];
    logic [DATA_WIDTH-1:0] exp_p  [0:READ_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_p [0:READ_LATENCY];
    logic [DATA_WIDTH-1:0] cmp_xor;
    logic                  mismatch;

    ne16_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (ag_load),
        .load_down (ag_load_down),
        .en        (ag_en),
        .dir_down  (cur_el.dir == DIR_DOWN),
        .addr      (ag_addr),
        .addr_nxt  (ag_addr_nxt),
        .tc        (ag_tc)
    );

    assign bus.a_t_o = ag_addr;

    // March sequencing: choose the position (element, phase, pass, address) of the next op.
    always_comb begin
        cur_el       = MARCH_C_MINUS[elem_q];
        nxt_elem     = elem_q;
        nxt_phase    = 1'b0;
        nxt_pass     = pass_q;
        run_last     = 1'b0;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_en        = 1'b0;
        start_acc    = (state_q == IDLE) && bus.start_i;
        if (state_q == IDLE) begin
            nxt_elem = '0;
            nxt_pass = 1'b0;
            ag_load  = start_acc;
        end else if (state_q == RUN) begin
            if (cur_el.has_op1 && !phase_q) begin
                nxt_phase = 1'b1;
            end else if (!ag_tc) begin
                ag_en = 1'b1;
            end else if (elem_q != ELEM_LAST) begin
                nxt_elem     = elem_q + 3'd1;
                ag_load      = 1'b1;
                ag_load_down = (MARCH_C_MINUS[nxt_elem].dir == DIR_DOWN);
            end else if (pass_q != PASS_LAST) begin
                nxt_pass = pass_q + 1'b1;
                nxt_elem = '0;
                ag_load  = 1'b1;
            end else begin
                run_last = 1'b1;
            end
        end
        issue    = start_acc || ((state_q == RUN) && !run_last);
        nxt_el   = MARCH_C_MINUS[nxt_elem];
        nxt_op   = nxt_phase ? nxt_el.op1 : nxt_el.op0;
        bg_full  = bg_word(nxt_pass, ag_addr_nxt[0]);
        nxt_data = bg_full[DATA_WIDTH-1:0] ^ {DATA_WIDTH{nxt_el.data_inv ^ nxt_phase}};
    end

    // Control FSM with registered status and SCM op outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            pass_q      <= 1'b0;
            drain_q     <= '0;
            bus.busy_o  <= 1'b0;
            bus.done_o  <= 1'b0;
            bus.bist_o  <= 1'b0;
            bus.csn_t_o <= 1'b1;
            bus.wen_t_o <= 1'b1;
            bus.d_t_o   <= '0;
        end else begin
            if (issue) begin
                elem_q      <= nxt_elem;
                phase_q     <= nxt_phase;
                pass_q      <= nxt_pass;
                bus.csn_t_o <= 1'b0;
                bus.wen_t_o <= nxt_op;
                bus.d_t_o   <= nxt_data;
            end
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        state_q    <= RUN;
                        bus.busy_o <= 1'b1;
                        bus.done_o <= 1'b0;
                        bus.bist_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (run_last) begin
                        state_q     <= DRAIN;
                        drain_q     <= DRAIN_INIT;
                        bus.csn_t_o <= 1'b1;
                        bus.wen_t_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q    <= IDLE;
                        bus.busy_o <= 1'b0;
                        bus.done_o <= 1'b1;
                        bus.bist_o <= 1'b0;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage p0 is the issued op; stage p[READ_LATENCY] lines up with q_t_i.
    // Read-valid delay line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= READ_LATENCY; i++)
                vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= issue && (nxt_op == OP_READ);
            for (int i = 1; i <= READ_LATENCY; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    // Expected data and address delay line (data path, not reset).
    always_ff @(posedge clk_i) begin
        exp_p[0]  <= nxt_data;
        addr_p[0] <= ag_addr_nxt;
        for (int i = 1; i <= READ_LATENCY; i++) begin
            exp_p[i]  <= exp_p[i-1];
            addr_p[i] <= addr_p[i-1];
        end
    end

    // Compare stage: syndrome of the read returning this cycle.
    always_comb begin
        cmp_xor  = bus.q_t_i ^ exp_p[READ_LATENCY];
        mismatch = vld_p[READ_LATENCY] && (cmp_xor != '0);
    end

    // Error statistics: cleared on accepted start, first failure captured once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.fail_o      <= 1'b0;
            bus.fail_addr_o <= '0;
            bus.fail_data_o <= '0;
            bus.err_count_o <= '0;
        end else if (start_acc) begin
            bus.fail_o      <= 1'b0;
            bus.fail_addr_o <= '0;
            bus.fail_data_o <= '0;
            bus.err_count_o <= '0;
        end else if (mismatch) begin
            bus.fail_o <= 1'b1;
            if (!bus.fail_o) begin
                bus.fail_addr_o <= addr_p[READ_LATENCY];
                bus.fail_data_o <= cmp_xor;
            end
            if (bus.err_count_o != ERR_MAX)
                bus.err_count_o <= bus.err_count_o + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_ne16_accumulator_scm_bist_ctrl.sv
// Self-checking bench for ne16_accumulator_scm_bist_ctrl with a behavioural SCM
// (stuck-at and decoder-coupling faults) and a string-driven March C- model.
module tb_ne16_accumulator_scm_bist_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 32;
    localparam int RL = 1;
    localparam int CW = 16;
`ifdef NE16_BIST_CHECKERBOARD_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int RUN_OPS = 10 * NW * NB;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ne16_accumulator_scm_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    ne16_accumulator_scm_bist_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .READ_LATENCY(RL), .CNT_WIDTH(CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fault configuration: 0 none, 1 stuck-at bit, 2 write to f_word also writes f_word2.
    int   fault_kind = 0;
    int   f_word = 0, f_bit = 0, f_word2 = 0;
    logic f_val = 1'b0;

    logic [DW-1:0] mem [NW];

    function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (fault_kind == 1 && a == f_word)
            r[f_bit] = f_val;
        return r;
    endfunction

    // Behavioural SCM BIST port, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.bist_o && !bus.csn_t_o) begin
            if (!bus.wen_t_o) begin
                mem[bus.a_t_o] <= bus.d_t_o;
                if (fault_kind == 2 && int'(bus.a_t_o) == f_word)
                    mem[f_word2] <= bus.d_t_o;
            end else begin
                bus.q_t_i <= rd_fault(int'(bus.a_t_o), mem[bus.a_t_o]);
            end
        end
    end

    // Reference march: '^' up, 'v' down, then op/polarity pairs.
    string march_def [6] = '{"^w0", "^r0w1", "^r1w0", "vr0w1", "vr1w0", "^r0"};

    op_t           exp_q [$];
    op_t           obs_q [$];
    int            exp_err;
    logic [AW-1:0] exp_faddr;
    logic [DW-1:0] exp_fdata;

    function automatic logic [DW-1:0] bgv(input int p, input int a);
        if (p == 0) return '0;
        return (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endfunction

    task automatic build_ref();
        logic [DW-1:0] rm [NW];
        logic [DW-1:0] val, got;
        op_t o;
        string s;
        int a;
        for (int i = 0; i < NW; i++) rm[i] = '0;
        exp_q.delete();
        exp_err = 0; exp_faddr = '0; exp_fdata = '0;
        for (int p = 0; p < NB; p++) begin
            for (int e = 0; e < 6; e++) begin
                s = march_def[e];
                for (int k = 0; k < NW; k++) begin
                    a = (s.getc(0) == "v") ? NW - 1 - k : k;
                    for (int j = 1; j < s.len(); j += 2) begin
                        val  = bgv(p, a) ^ ((s.getc(j+1) == "1") ? {DW{1'b1}} : {DW{1'b0}});
                        o.wr = (s.getc(j) == "w");
                        o.a  = AW'(a);
                        o.d  = val;
                        exp_q.push_back(o);
                        if (o.wr) begin
                            rm[a] = val;
                            if (fault_kind == 2 && a == f_word) rm[f_word2] = val;
                        end else begin
                            got = rd_fault(a, rm[a]);
                            if (got != val) begin
                                if (exp_err == 0) begin
                                    exp_faddr = AW'(a);
                                    exp_fdata = got ^ val;
                                end
                                exp_err++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_march(input string tag, input int spur);
        int  s, first_busy, busy_cnt, done_cyc, nbad;
        op_t o;
        build_ref();
        obs_q.delete();
        first_busy = -1; busy_cnt = 0; done_cyc = -1;
        @(negedge clk);
        bus.start_i = 1'b1;
        s = cyc;
        for (int t = 0; t < RUN_OPS + 50; t++) begin
            @(negedge clk);
            bus.start_i = (spur > 0) && (cyc - s == spur);
            if (t == 0)
                check_eq({tag, "_cleared"}, {bus.done_o, bus.fail_o, bus.err_count_o}, '0);
            if (bus.busy_o) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc - s;
            end
            if (bus.bist_o && !bus.csn_t_o) begin
                o.wr = !bus.wen_t_o; o.a = bus.a_t_o; o.d = bus.d_t_o;
                obs_q.push_back(o);
            end
            if (bus.done_o) begin
                done_cyc = cyc - s;
                break;
            end
        end
        bus.start_i = 1'b0;
        check_eq({tag, "_done_cycle"}, done_cyc, 1 + RUN_OPS + RL);
        check_eq({tag, "_first_busy"}, first_busy, 1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, RUN_OPS + RL);
        check_eq({tag, "_op_count"}, obs_q.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].wr != exp_q[i].wr || obs_q[i].a != exp_q[i].a ||
                (exp_q[i].wr && obs_q[i].d != exp_q[i].d))
                nbad++;
        end
        check_eq({tag, "_op_seq_bad"}, nbad, 0);
        check_eq({tag, "_fail"}, bus.fail_o, exp_err > 0);
        check_eq({tag, "_err_count"}, bus.err_count_o, exp_err);
        check_eq({tag, "_fail_addr"}, bus.fail_addr_o, exp_faddr);
        check_eq({tag, "_fail_data"}, bus.fail_data_o, exp_fdata);
        check_eq({tag, "_idle_bist_busy"}, {bus.bist_o, bus.busy_o, bus.csn_t_o}, 3'b001);
    endtask

    task automatic reset_mid_run(input int at);
        int s;
        @(negedge clk);
        bus.start_i = 1'b1;
        s = cyc;
        for (int t = 0; t < at + 5; t++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (cyc - s >= at) break;
        end
        check_eq("rst_pre_busy", bus.busy_o, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rst_now_bist", bus.bist_o, 1'b0);
        check_eq("rst_now_csn", bus.csn_t_o, 1'b1);
        check_eq("rst_now_busy", bus.busy_o, 1'b0);
        check_eq("rst_now_done_fail_err", {bus.done_o, bus.fail_o, bus.err_count_o}, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.start_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy_o, 1'b0);
        check_eq("rst_done", bus.done_o, 1'b0);
        check_eq("rst_fail", bus.fail_o, 1'b0);
        check_eq("rst_fail_addr", bus.fail_addr_o, '0);
        check_eq("rst_fail_data", bus.fail_data_o, '0);
        check_eq("rst_err_count", bus.err_count_o, '0);
        check_eq("rst_bist", bus.bist_o, 1'b0);
        check_eq("rst_csn", bus.csn_t_o, 1'b1);
        check_eq("rst_wen", bus.wen_t_o, 1'b1);
        check_eq("rst_a", bus.a_t_o, '0);
        check_eq("rst_d", bus.d_t_o, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_no_start", bus.busy_o, 1'b0);

        fault_kind = 0;
        run_march("clean", 0);
`ifdef NE16_BIST_CHECKERBOARD_EN
        if (obs_q.size() > 10 * NW + 1) begin
            check_eq("cb_w0_data", obs_q[10*NW].d, 32'h5555_5555);
            check_eq("cb_w1_data", obs_q[10*NW+1].d, 32'hAAAA_AAAA);
            check_eq("cb_w1_addr", obs_q[10*NW+1].a, 1);
        end else begin
            check_eq("cb_op_count", obs_q.size(), 10 * NW + 2);
        end
`endif

        fault_kind = 1; f_word = 7; f_bit = 3; f_val = 1'b1;
        run_march("sa1_w7b3", 0);
`ifndef NE16_BIST_CHECKERBOARD_EN
        check_eq("sa1_literal_err", bus.err_count_o, 3);
        check_eq("sa1_literal_addr", bus.fail_addr_o, 7);
        check_eq("sa1_literal_data", bus.fail_data_o, 32'h0000_0008);
`endif

        fault_kind = 2; f_word = 2; f_word2 = 3;
        run_march("dec_2to3", 0);
`ifndef NE16_BIST_CHECKERBOARD_EN
        check_eq("dec_literal_addr", bus.fail_addr_o, 3);
        check_eq("dec_literal_data", bus.fail_data_o, 32'hFFFF_FFFF);
`endif

        fault_kind = 0;
        run_march("spurious_start", 50);

        reset_mid_run(100);
        run_march("after_rst", 0);

        for (int r = 0; r < 4; r++) begin
            fault_kind = int'($urandom_range(1, 2));
            f_word     = int'($urandom_range(0, NW - 1));
            f_bit      = int'($urandom_range(0, DW - 1));
            f_val      = 1'($urandom_range(0, 1));
            f_word2    = (f_word + int'($urandom_range(1, NW - 1))) % NW;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_march($sformatf("rand%0d", r), int'($urandom_range(2, 300)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
